sklansky_serial_subtractor: RTL and testbench
=============================================

Name: sklansky_serial_subtractor

Overview:
- Byte-serial multi-byte subtractor, the inverse operation of the registered 8-bit Sklansky adder.
- Computes A − B for NUM_BYTES-wide operands presented LSB byte first, one byte pair per handshake, over the 8-bit pin budget.
- Each byte is computed by an 8-bit Sklansky prefix slice with carry-in: A + ~B + cin. The carry is chained across bytes in a register.
- Difference bytes stream out with valid/ready. Borrow and zero flags are reported on the last byte.

Parameters:
- NUM_BYTES, 4, number of byte slices per word (≥2); the word is NUM_BYTES×8 bits.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  global enable; when low, all state is frozen
- in_valid  in  1  operand byte pair valid
- in_ready  out  1  block can accept an operand byte pair
- a_byte  in  8  minuend byte (LSB byte first)
- b_byte  in  8  subtrahend byte
- out_valid  out  1  diff_byte valid
- out_ready  in  1  downstream accepts diff_byte
- diff_byte  out  8  difference byte
- out_last  out  1  diff_byte is the MSB byte of the word
- borrow_out  out  1  word borrow (A < B unsigned); meaningful only when out_last=1
- zero_out  out  1  whole-word difference == 0; meaningful only when out_last=1

Behaviour:
- Reset (reset_n=0 at a clock edge): all outputs 0, carry_reg=0, zero_acc=1, byte_idx=0, state=IDLE. Reset has priority over enable. A reset mid-word discards the partial word; the next accepted byte is byte 0.
- enable=0: in_ready=0; registers hold; out_valid/diff_byte remain stable. A downstream out_ready is ignored (no pop).
- in_ready = enable & (~out_valid | out_ready). This gives a one-entry output register with pass-through on pop. Full throughput is 1 byte/cycle.
- Input transfer = in_valid & in_ready.
- On an input transfer:
  - cin = (byte_idx==0) ? 1 : carry_reg.
  - {cout, s} = a_byte + ~b_byte + cin, computed by the Sklansky slice.
  - diff_byte <= s; out_valid <= 1; out_last <= (byte_idx==NUM_BYTES-1).
  - carry_reg <= cout.
  - zero_now = zero_src & (s==8'h00), where zero_src = 1 on byte 0, else zero_acc.
  - On the last byte: borrow_out <= ~cout; zero_out <= zero_now; byte_idx <= 0; zero_acc <= 1; state <= IDLE.
  - Otherwise: borrow_out <= 0; zero_out <= 0; byte_idx <= byte_idx+1; zero_acc <= zero_now; state <= BUSY.
- Pop without a new transfer (out_valid & out_ready & enable & ~transfer): out_valid <= 0; out_last, borrow_out and zero_out <= 0.
- Simultaneous pop and transfer: the new byte replaces the popped one; out_valid stays 1.
- Latency: 1 cycle from input transfer to out_valid.
- Stall (out_valid=1, out_ready=0): in_ready=0; diff_byte and all flags hold unchanged.
- FSM:
  - IDLE (byte_idx=0, awaiting byte 0).
  - BUSY (mid-word).
  - IDLE→BUSY on transfer when NUM_BYTES>1.
  - BUSY→IDLE on the last-byte transfer.
  - No timeout; the word stays open indefinitely.
- Wrap-around: byte_idx counts 0..NUM_BYTES-1 and then wraps to 0. Back-to-back words are allowed with no gap cycle.
- Arithmetic is unsigned modulo 2^(8·NUM_BYTES). Signed overflow is not reported.

Decomposition:
- Package sklansky_pkg holds:
  - BYTE_W=8.
  - FSM encoding, IDLE=1'b0, BUSY=1'b1.
  - Function clog2 for the byte_idx width.
- Sub-module sklansky_prefix8_cin is purely combinational:
  - Inputs: a[7:0], b[7:0], cin.
  - Outputs: sum[7:0], cout.
  - Built from generate_propagate, gray_cell and black_cell, with cin injected as g[0][0].
  - The subtractor instantiates it with b=~b_byte.
- The top level holds the FSM, byte counter, carry/zero registers and output buffer.

Test Plan:
- Basic subtract, NUM_BYTES=4: A=0x12345678, B=0x00000001, out_ready=1 → diff bytes 77,56,34,12 on consecutive cycles; out_last only on 0x12; borrow_out=0; zero_out=0.
- Underflow: A=0x00000000, B=0x00000001 → bytes FF,FF,FF,FF; borrow_out=1 on the last byte; zero_out=0.
- Equality: A=B=0xDEADBEEF → bytes 00×4; zero_out=1 and borrow_out=0 on the last byte. Follow with back-to-back A=0x00000100, B=0x00000001 → bytes FF,00,00,00; zero_out=0. This proves zero_acc and carry_reg re-init at the word boundary.
- Backpressure: hold out_ready=0 for 5 cycles after byte 1 → in_ready=0; diff_byte holds 0x56; no byte lost or duplicated after release; final word correct.
- Reset mid-word: accept 2 bytes, assert reset_n=0 for 1 cycle → out_valid=0, all outputs 0. A fresh word A=0x00000005, B=0x00000003 → bytes 02,00,00,00; borrow_out=0.
- Enable gating: drop enable for 3 cycles mid-word with in_valid=1 and out_ready=1 → in_ready=0; no state change; the result after re-enable matches an ungated run.

Source files
------------

// File: rtl/sklansky_pkg.sv
// sklansky_pkg: shared width, FSM encoding and sizing helper for the byte-serial Sklansky subtractor.
`default_nettype none

package sklansky_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sklansky_prefix8_cin.sv
// sklansky_prefix8_cin: combinational 8-bit Sklansky prefix adder with carry-in folded into bit 0's generate.
`default_nettype none

module generate_propagate (
   input  logic a,
   input  logic b,
   output logic g,
   output logic p
);
   assign g = a & b;
   assign p = a ^ b;
endmodule

module gray_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   output logic g
);
   assign g = g_hi | (p_hi & g_lo);
endmodule

module black_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g,
   output logic p
);
   assign g = g_hi | (p_hi & g_lo);
   assign p = p_hi & p_lo;
endmodule

module sklansky_level
   import sklansky_pkg::*;
#(
   parameter int LEVEL = 0
) (
   input  logic [BYTE_W-1:0] g_in,
   input  logic [BYTE_W-1:0] p_in,
   output logic [BYTE_W-1:0] g_out,
   output logic [BYTE_W-1:0] p_out
);
   // Each bit with bit LEVEL set merges with the top of the lower half of its 2^(LEVEL+1) block;
   // when that block starts at bit 0 the result is a final carry, so only a gray cell is needed.
   for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
      if (((i >> LEVEL) & 1) == 1) begin : g_merge
         localparam int J = ((i >> LEVEL) << LEVEL) - 1;
         if (((i >> (LEVEL + 1)) << (LEVEL + 1)) == 0) begin : g_gray
            gray_cell u_gray (
               .g_hi (g_in[i]),
               .p_hi (p_in[i]),
               .g_lo (g_in[J]),
               .g    (g_out[i])
            );
            assign p_out[i] = p_in[i];
         end else begin : g_black
            black_cell u_black (
               .g_hi (g_in[i]),
               .p_hi (p_in[i]),
               .g_lo (g_in[J]),
               .p_lo (p_in[J]),
               .g    (g_out[i]),
               .p    (p_out[i])
            );
         end
      end else begin : g_pass
         assign g_out[i] = g_in[i];
         assign p_out[i] = p_in[i];
      end
   end
endmodule

module sklansky_prefix8_cin
   import sklansky_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout
);
   logic [BYTE_W-1:0] w_graw;
   logic [BYTE_W-1:0] w_g0, w_g1, w_g2, w_g3;
   logic [BYTE_W-1:0] w_p0, w_p1, w_p2, w_p3;
   logic [BYTE_W-1:0] w_carry;
   logic              w_unused_p;

   for (genvar i = 0; i < BYTE_W; i++) begin : g_gp
      generate_propagate u_gp (
         .a (a[i]),
         .b (b[i]),
         .g (w_graw[i]),
         .p (w_p0[i])
      );
   end

   assign w_g0 = {w_graw[BYTE_W-1:1], w_graw[0] | (w_p0[0] & cin)};

   sklansky_level #(.LEVEL(0)) u_l0 (.g_in(w_g0), .p_in(w_p0), .g_out(w_g1), .p_out(w_p1));
   sklansky_level #(.LEVEL(1)) u_l1 (.g_in(w_g1), .p_in(w_p1), .g_out(w_g2), .p_out(w_p2));
   sklansky_level #(.LEVEL(2)) u_l2 (.g_in(w_g2), .p_in(w_p2), .g_out(w_g3), .p_out(w_p3));

   assign w_carry    = {w_g3[BYTE_W-2:0], cin};
   assign sum        = w_p0 ^ w_carry;
   assign cout       = w_g3[BYTE_W-1];
   assign w_unused_p = ^w_p3;
endmodule

`default_nettype wire

// File: rtl/sklansky_serial_subtractor.sv
// sklansky_serial_subtractor: byte-serial A-B over NUM_BYTES bytes, LSB first, with borrow/zero on the last byte.
`default_nettype none

module sklansky_serial_subtractor
   import sklansky_pkg::*;
#(
   parameter int NUM_BYTES = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] a_byte,
   input  logic [BYTE_W-1:0] b_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] diff_byte,
   output logic              out_last,
   output logic              borrow_out,
   output logic              zero_out
);
   localparam int                IDX_W    = clog2(NUM_BYTES);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BYTES - 1);

   state_t              r_state;
   logic [IDX_W-1:0]    r_byte_idx;
   logic                r_carry;
   logic                r_zero_acc;
   logic                r_out_valid;
   logic [BYTE_W-1:0]   r_diff;
   logic                r_last;
   logic                r_borrow;
   logic                r_zero;

   logic                w_in_ready;
   logic                w_xfer;
   logic                w_is_last;
   logic                w_cin;
   logic                w_zero_src;
   logic                w_zero_now;
   logic [BYTE_W-1:0]   w_sum;
   logic                w_cout;

   // One-entry output register; a pop in the same cycle frees the slot for a new byte.
   assign w_in_ready = enable & (~r_out_valid | out_ready);
   assign w_xfer     = in_valid & w_in_ready;
   assign w_is_last  = (r_byte_idx == LAST_IDX);
   assign w_cin      = (r_state == IDLE) ? 1'b1 : r_carry;
   assign w_zero_src = (r_state == IDLE) ? 1'b1 : r_zero_acc;
   assign w_zero_now = w_zero_src & (w_sum == '0);

   sklansky_prefix8_cin u_slice (
      .a    (a_byte),
      .b    (~b_byte),
      .cin  (w_cin),
      .sum  (w_sum),
      .cout (w_cout)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_byte_idx  <= '0;
         r_carry     <= 1'b0;
         r_zero_acc  <= 1'b1;
         r_out_valid <= 1'b0;
         r_diff      <= '0;
         r_last      <= 1'b0;
         r_borrow    <= 1'b0;
         r_zero      <= 1'b0;
      end else if (enable) begin
         if (w_xfer) begin
            r_diff      <= w_sum;
            r_out_valid <= 1'b1;
            r_last      <= w_is_last;
            r_carry     <= w_cout;
            if (w_is_last) begin
               r_borrow   <= ~w_cout;
               r_zero     <= w_zero_now;
               r_byte_idx <= '0;
               r_zero_acc <= 1'b1;
               r_state    <= IDLE;
            end else begin
               r_borrow   <= 1'b0;
               r_zero     <= 1'b0;
               r_byte_idx <= r_byte_idx + 1'b1;
               r_zero_acc <= w_zero_now;
               r_state    <= BUSY;
            end
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
            r_borrow    <= 1'b0;
            r_zero      <= 1'b0;
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = r_out_valid;
   assign diff_byte  = r_diff;
   assign out_last   = r_last;
   assign borrow_out = r_borrow;
   assign zero_out   = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_sklansky_serial_subtractor.sv
// tb_sklansky_serial_subtractor: scenario tasks plus a word-level arithmetic reference feeding an expectation queue.
`default_nettype none

module tb_sklansky_serial_subtractor;
   localparam int NB = 4;
   localparam int W  = NB * 8;

   logic       clock = 1'b0;
   logic       reset_n, enable, in_valid, out_ready;
   logic [7:0] a_byte, b_byte;
   logic       in_ready, out_valid, out_last, borrow_out, zero_out;
   logic [7:0] diff_byte;

   typedef struct packed {
      logic [7:0] d;
      logic       last;
      logic       borrow;
      logic       zero;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   rand_ready = 1'b0;

   always #5 clock = ~clock;

   sklansky_serial_subtractor #(.NUM_BYTES(NB)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (enable),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_byte     (a_byte),
      .b_byte     (b_byte),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff_byte  (diff_byte),
      .out_last   (out_last),
      .borrow_out (borrow_out),
      .zero_out   (zero_out)
   );

   // Reference: whole-word unsigned subtraction, split into expected output bytes.
   function automatic void push_word(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] d;
      exp_t         e;
      d = a - b;
      for (int k = 0; k < NB; k++) begin
         e.d      = d[8*k +: 8];
         e.last   = (k == NB - 1);
         e.borrow = (k == NB - 1) && (a < b);
         e.zero   = (k == NB - 1) && (d == '0);
         q.push_back(e);
      end
   endfunction

   // Every popped output byte is checked against the head of the expectation queue.
   always @(negedge clock) begin
      exp_t e;
      if (reset_n && enable && out_valid && out_ready) begin
         n_checks++;
         if (q.size() == 0) begin
            $display("FAIL unexpected_output diff=%h last=%b but no byte expected", diff_byte, out_last);
         end else begin
            e = q.pop_front();
            if ({diff_byte, out_last, borrow_out, zero_out} !== {e.d, e.last, e.borrow, e.zero})
               $display("FAIL out_byte got d=%h l=%b b=%b z=%b expected d=%h l=%b b=%b z=%b",
                        diff_byte, out_last, borrow_out, zero_out, e.d, e.last, e.borrow, e.zero);
            else
               n_pass++;
         end
      end
   end

   always @(posedge clock) begin
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic send_byte(input logic [7:0] a, input logic [7:0] b);
      int waited;
      waited   = 0;
      a_byte   = a;
      b_byte   = b;
      in_valid = 1'b1;
      @(negedge clock);
      while (!in_ready && waited < 200) begin
         @(negedge clock);
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         $display("FAIL send_timeout in_ready=%b expected 1", in_ready);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b);
      push_word(a, b);
      for (int k = 0; k < NB; k++) send_byte(a[8*k +: 8], b[8*k +: 8]);
   endtask

   task automatic drain();
      int w;
      w = 0;
      in_valid = 1'b0;
      while (q.size() != 0 && w < 500) begin
         @(posedge clock);
         w++;
      end
      n_checks++;
      if (q.size() != 0) $display("FAIL drain_timeout pending=%0d expected 0", q.size());
      else n_pass++;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a_byte = '0; b_byte = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_checks++;
      if ({out_valid, diff_byte, out_last, borrow_out, zero_out} !== 12'h000)
         $display("FAIL reset_outputs got v=%b d=%h l=%b b=%b z=%b expected all 0",
                  out_valid, diff_byte, out_last, borrow_out, zero_out);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b expected 1", in_ready);
      else n_pass++;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send_word(32'h1234_5678, 32'h0000_0001);
      drain();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL basic_idle_valid got %b expected 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_underflow();
      out_ready = 1'b1;
      send_word(32'h0000_0000, 32'h0000_0001);
      drain();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      send_word(32'hDEAD_BEEF, 32'hDEAD_BEEF);
      send_word(32'h0000_0100, 32'h0000_0001);
      drain();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      push_word(32'h1234_5678, 32'h0000_0001);
      send_byte(8'h78, 8'h01);
      send_byte(8'h56, 8'h00);
      out_ready = 1'b0;
      a_byte = 8'h34; b_byte = 8'h00; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || diff_byte !== 8'h56)
            $display("FAIL stall_hold cycle=%0d got rdy=%b v=%b d=%h expected rdy=0 v=1 d=56",
                     c, in_ready, out_valid, diff_byte);
         else n_pass++;
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      send_byte(8'h34, 8'h00);
      send_byte(8'h12, 8'h00);
      drain();
   endtask

   task automatic test_reset_midword();
      out_ready = 1'b1;
      push_word(32'h8877_6655, 32'h1122_3344);
      send_byte(8'h55, 8'h44);
      send_byte(8'h66, 8'h33);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      q.delete();
      @(negedge clock);
      n_checks++;
      if ({out_valid, diff_byte, out_last, borrow_out, zero_out} !== 12'h000)
         $display("FAIL midword_reset got v=%b d=%h l=%b b=%b z=%b expected all 0",
                  out_valid, diff_byte, out_last, borrow_out, zero_out);
      else n_pass++;
      @(posedge clock);
      #1;
      send_word(32'h0000_0005, 32'h0000_0003);
      drain();
   endtask

   task automatic test_enable_gating();
      logic [W-1:0] a, b;
      logic [7:0]   held;
      a = $urandom; b = $urandom;
      out_ready = 1'b1;
      push_word(a, b);
      send_byte(a[7:0], b[7:0]);
      send_byte(a[15:8], b[15:8]);
      held   = q[0].d;
      enable = 1'b0;
      a_byte = a[23:16]; b_byte = b[23:16]; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || diff_byte !== held)
            $display("FAIL enable_hold cycle=%0d got rdy=%b v=%b d=%h expected rdy=0 v=1 d=%h",
                     c, in_ready, out_valid, diff_byte, held);
         else n_pass++;
      end
      @(posedge clock);
      #1;
      enable = 1'b1;
      send_byte(a[23:16], b[23:16]);
      send_byte(a[31:24], b[31:24]);
      drain();
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      rand_ready = 1'b1;
      for (int n = 0; n < 24; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a + W'($urandom_range(1, 3));
            default: b = $urandom;
         endcase
         send_word(a, b);
         if ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clock);
            #1;
         end
      end
      in_valid   = 1'b0;
      rand_ready = 1'b0;
      @(posedge clock);
      #2;
      out_ready = 1'b1;
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_back_to_back();
      test_backpressure();
      test_reset_midword();
      test_enable_gating();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
